instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of InstructionMemory. Owns the program counter and drives ReadAddress.

---
 rtl/instruction_fetch_unit_pkg.sv | 33 +++
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit_pc_next_select.sv | 44 ++++
 rtl/instruction_fetch_unit.sv | 61 ++++++
 tb/tb_instruction_fetch_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the fetch stage and the decode logic downstream of it.
package instruction_fetch_unit_pkg;

  localparam int          PC_WIDTH        = 32;
  localparam int          IMEM_ADDR_WIDTH = 6;
  localparam logic [31:0] RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

  // Primary opcodes used by decode
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes used by decode
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // What the IF/ID register does on the next edge
  typedef enum logic [1:0] {
    IFID_LOAD,   // capture the freshly fetched instruction
    IFID_HOLD,   // stall: keep current contents
    IFID_FLUSH   // redirect: replace wrong-path slot with a bubble
  } ifid_action_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, ID-stage control inputs and the IF/ID outputs.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic [IMEM_ADDR_WIDTH-1:0] ReadAddress;
  logic [31:0]                Instruction;
  logic                       Stall;
  logic                       BranchTaken;
  logic [15:0]                BranchOffset;
  logic                       Jump;
  logic [25:0]                JumpIndex;
  logic [31:0]                IfIdInstruction;
  logic [PC_WIDTH-1:0]        IfIdPcPlus4;
  logic                       IfIdValid;
  logic [PC_WIDTH-1:0]        Pc;

  // Fetch unit side
  modport master (
    output ReadAddress, IfIdInstruction, IfIdPcPlus4, IfIdValid, Pc,
    input  Instruction, Stall, BranchTaken, BranchOffset, Jump, JumpIndex
  );

  // Environment side: instruction memory plus ID-stage hazard/branch logic
  modport slave (
    input  ReadAddress, IfIdInstruction, IfIdPcPlus4, IfIdValid, Pc,
    output Instruction, Stall, BranchTaken, BranchOffset, Jump, JumpIndex
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_next_select.sv
// Combinational next-PC selection: target computation and redirect/stall priority.
module pc_next_select
  import instruction_fetch_unit_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] ifid_pc_plus4,
  input  logic                ifid_valid,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [15:0]         branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [PC_WIDTH-1:0] pc_next,
  output ifid_action_e        ifid_action
);

  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = ifid_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target   = {ifid_pc_plus4[31:28], jump_index, 2'b00};

  // Priority: jump, taken branch, stall, sequential; a bubble in ID cannot redirect or stall
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_next     = pc_plus4;
    ifid_action = IFID_LOAD;
    if (ifid_valid) begin
      if (jump) begin
        pc_next     = jump_target;
        ifid_action = IFID_FLUSH;
      end else if (branch_taken) begin
        pc_next     = branch_target;
        ifid_action = IFID_FLUSH;
      end else if (stall) begin
        pc_next     = pc;
        ifid_action = IFID_HOLD;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = RESET_PC
) (
  input logic                       clk,
  input logic                       reset,
  instruction_fetch_unit_if.master  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] pc_next;
  ifid_action_e        ifid_action;

  pc_next_select u_pc_next_select (
    .pc            (pc_q),
    .ifid_pc_plus4 (bus.IfIdPcPlus4),
    .ifid_valid    (bus.IfIdValid),
    .stall         (bus.Stall),
    .branch_taken  (bus.BranchTaken),
    .branch_offset (bus.BranchOffset),
    .jump          (bus.Jump),
    .jump_index    (bus.JumpIndex),
    .pc_plus4      (pc_plus4),
    .pc_next       (pc_next),
    .ifid_action   (ifid_action)
  );

  // Word address wraps naturally by dropping the upper PC bits
  assign bus.ReadAddress = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign bus.Pc          = pc_q;

  // PC and IF/ID pipeline register, synchronous reset has top priority
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pc_q                <= RESET_VALUE;
      bus.IfIdInstruction <= NOP_INSTR;
      bus.IfIdPcPlus4     <= '0;
      bus.IfIdValid       <= 1'b0;
    end else begin
      pc_q <= pc_next;
      case (ifid_action)
        IFID_LOAD: begin
          bus.IfIdInstruction <= bus.Instruction;
          bus.IfIdPcPlus4     <= pc_plus4;
          bus.IfIdValid       <= 1'b1;
        end
        IFID_FLUSH: begin
          bus.IfIdInstruction <= NOP_INSTR;
          bus.IfIdPcPlus4     <= '0;
          bus.IfIdValid       <= 1'b0;
        end
        default: ;  // IFID_HOLD keeps contents
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  logic [31:0] imem [64];

  int vectors;
  int miscompares;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Zero-latency instruction memory model
  assign bus.Instruction = imem[bus.ReadAddress];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, bus.IfIdInstruction, instr);
    check({tag, ".pc4"},   bus.IfIdPcPlus4,     pc4);
    check({tag, ".valid"}, {31'b0, bus.IfIdValid}, {31'b0, valid});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    imem[0] = 32'h0109_3822;
    for (int i = 1; i < 64; i++) imem[i] = 32'hA500_0000 + 32'(i);

    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchOffset = 16'h0;
    bus.Jump         = 1'b0;
    bus.JumpIndex    = 26'h0;

    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst.pc", bus.Pc, 32'h0);
    check("rst.ra", {26'b0, bus.ReadAddress}, 32'd0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);

    // Free run: first instruction lands one clock after its PC
    tick();
    check("run1.pc", bus.Pc, 32'h4);
    check("run1.ra", {26'b0, bus.ReadAddress}, 32'd1);
    check_ifid("run1", 32'h0109_3822, 32'h4, 1'b1);
    tick();
    check("run2.pc", bus.Pc, 32'h8);
    check("run2.ra", {26'b0, bus.ReadAddress}, 32'd2);
    check_ifid("run2", 32'hA500_0001, 32'h8, 1'b1);

    // Two-cycle stall at Pc=8
    bus.Stall = 1'b1;
    tick();
    check("stall1.pc", bus.Pc, 32'h8);
    check_ifid("stall1", 32'hA500_0001, 32'h8, 1'b1);
    tick();
    check("stall2.pc", bus.Pc, 32'h8);
    check_ifid("stall2", 32'hA500_0001, 32'h8, 1'b1);
    bus.Stall = 1'b0;
    tick();
    check("release.pc", bus.Pc, 32'hC);
    check("release.ra", {26'b0, bus.ReadAddress}, 32'd3);
    check_ifid("release", 32'hA500_0002, 32'hC, 1'b1);

    // Backward branch from IfIdPcPlus4=8
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("pre_br.pc4", bus.IfIdPcPlus4, 32'h8);
    bus.BranchTaken  = 1'b1;
    bus.BranchOffset = 16'hFFFE;
    tick();
    check("br_back.pc", bus.Pc, 32'h0);
    check_ifid("br_back", 32'h0, 32'h0, 1'b0);

    // Branch while ID holds a bubble is ignored
    bus.BranchOffset = 16'h0003;
    tick();
    check("br_bubble.pc", bus.Pc, 32'h4);
    check_ifid("br_bubble", 32'h0109_3822, 32'h4, 1'b1);
    bus.BranchTaken = 1'b0;
    tick();
    check("pre_fwd.pc4", bus.IfIdPcPlus4, 32'h8);

    // Forward branch: 8 + 3*4
    bus.BranchTaken = 1'b1;
    tick();
    check("br_fwd.pc", bus.Pc, 32'h14);
    check_ifid("br_fwd", 32'h0, 32'h0, 1'b0);
    bus.BranchTaken = 1'b0;
    tick();
    check_ifid("post_fwd", 32'hA500_0005, 32'h18, 1'b1);

    // Jump beats simultaneous branch and stall
    bus.Jump        = 1'b1;
    bus.JumpIndex   = 26'h10;
    bus.BranchTaken = 1'b1;
    bus.Stall       = 1'b1;
    tick();
    check("jump.pc", bus.Pc, 32'h40);
    check("jump.ra", {26'b0, bus.ReadAddress}, 32'h10);
    check_ifid("jump", 32'h0, 32'h0, 1'b0);
    bus.Jump        = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.Stall       = 1'b0;

    // Run to 0xFC, then wrap the word address
    repeat (47) tick();
    check("top.pc", bus.Pc, 32'hFC);
    check("top.ra", {26'b0, bus.ReadAddress}, 32'h3F);
    tick();
    check("wrap.pc", bus.Pc, 32'h100);
    check("wrap.ra", {26'b0, bus.ReadAddress}, 32'h0);
    check_ifid("wrap", 32'hA500_003F, 32'h100, 1'b1);

    // Reset beats stall and jump
    bus.Stall     = 1'b1;
    bus.Jump      = 1'b1;
    bus.JumpIndex = 26'h3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid.pc", bus.Pc, 32'h0);
    check_ifid("rst_mid", 32'h0, 32'h0, 1'b0);

    // With a bubble in ID the held stall/jump are ignored
    tick();
    check("post_rst.pc", bus.Pc, 32'h4);
    check_ifid("post_rst", 32'h0109_3822, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
